regfile_read_sequencer: RTL and testbench

//  Read-side controller for the BitCell register array. Accepts a two-operand read request.

---
 rtl/regfile_read_sequencer_if.sv | 49 ++++
 rtl/regfile_read_sequencer.sv | 150 +++++++++++++++
 tb/tb_regfile_read_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_read_sequencer_if
// Groups the request handshake, the write snoop, the array wordline/bitline
// bus and the operand handshake of the register-file read sequencer.
//
//   req_valid / req_ready      request handshake (decode side)
//   rs1, rs2                   operand addresses
//   wr_en, wr_addr, wr_data    array write snooped for bypass
//   ReadEnable1/2              one-hot wordlines to the array read ports
//   Bitline1/2                 shared read buses coming back from the array
//   rd_valid / rd_ready        operand handshake (consumer side)
//   rd_data1, rd_data2         registered operands
//
// Modports: slave  - the sequencer itself
//           master - the surrounding decode/array/consumer logic
// -----------------------------------------------------------------------------
interface regfile_read_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int WIDTH    = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   rs1;
    logic [ADDR_W-1:0]   rs2;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic [NUM_REGS-1:0] ReadEnable1;
    logic [NUM_REGS-1:0] ReadEnable2;
    logic [WIDTH-1:0]    Bitline1;
    logic [WIDTH-1:0]    Bitline2;
    logic                rd_valid;
    logic                rd_ready;
    logic [WIDTH-1:0]    rd_data1;
    logic [WIDTH-1:0]    rd_data2;

    modport slave (
        input  req_valid, rs1, rs2, wr_en, wr_addr, wr_data,
               Bitline1, Bitline2, rd_ready,
        output req_ready, ReadEnable1, ReadEnable2, rd_valid, rd_data1, rd_data2
    );

    modport master (
        output req_valid, rs1, rs2, wr_en, wr_addr, wr_data,
               Bitline1, Bitline2, rd_ready,
        input  req_ready, ReadEnable1, ReadEnable2, rd_valid, rd_data1, rd_data2
    );
endinterface

// File: rtl/regfile_read_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_read_sequencer
// Read-side controller for the BitCell register array. A two-operand request
// is accepted in IDLE, the matching one-hot wordlines are driven for two
// cycles (DRIVE lets the bitlines settle, SAMPLE captures them), and the
// captured operands are held with rd_valid until the consumer takes them.
// A write to the same register landing at the sample edge is bypassed.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rst   - asynchronous active-low reset
//   bus   - regfile_read_sequencer_if.slave (request, write snoop,
//           wordlines/bitlines, operand handshake)
//
// Parameters:
//   NUM_REGS - registers in the array (one wordline each per port)
//   ADDR_W   - register address width, NUM_REGS == 2**ADDR_W
//   WIDTH    - bits per register / bitline bus
//   ZERO_REG - nonzero: address 0 reads as zero and drives no wordline
// -----------------------------------------------------------------------------
module regfile_read_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_read_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_r;
    logic                req_ready_r;
    logic [ADDR_W-1:0]   rs1_r;
    logic [ADDR_W-1:0]   rs2_r;
    logic [NUM_REGS-1:0] wl1_r;
    logic [NUM_REGS-1:0] wl2_r;
    logic                rd_valid_r;
    logic [WIDTH-1:0]    rd_data1_r;
    logic [WIDTH-1:0]    rd_data2_r;

    // One-hot wordline for an address; the hard-wired zero register has no
    // wordline so its bus is left floating and never sampled.
    function automatic logic [NUM_REGS-1:0] wordline_decode(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] wl;
        wl = {NUM_REGS{1'b0}};
        if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
            wl = {NUM_REGS{1'b0}};
        end else begin
            wl[addr] = 1'b1;
        end
        return wl;
    endfunction

    // Operand value at the sample edge: zero register first, then a write
    // landing on the same edge (the cell has not updated yet), then the bus.
    function automatic logic [WIDTH-1:0] operand_select(
        input logic [ADDR_W-1:0] addr,
        input logic              snoop_en,
        input logic [ADDR_W-1:0] snoop_addr,
        input logic [WIDTH-1:0]  snoop_data,
        input logic [WIDTH-1:0]  bitline
    );
        logic [WIDTH-1:0] val;
        if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
            val = {WIDTH{1'b0}};
        end else if (snoop_en && (snoop_addr == addr)) begin
            val = snoop_data;
        end else begin
            val = bitline;
        end
        return val;
    endfunction

    // Sequencer FSM; every output is a register so wordlines never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rs1_r       <= {ADDR_W{1'b0}};
            rs2_r       <= {ADDR_W{1'b0}};
            wl1_r       <= {NUM_REGS{1'b0}};
            wl2_r       <= {NUM_REGS{1'b0}};
            rd_valid_r  <= 1'b0;
            rd_data1_r  <= {WIDTH{1'b0}};
            rd_data2_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rs1_r       <= bus.rs1;
                        rs2_r       <= bus.rs2;
                        wl1_r       <= wordline_decode(bus.rs1);
                        wl2_r       <= wordline_decode(bus.rs2);
                        req_ready_r <= 1'b0;
                        state_r     <= ST_DRIVE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    // Wordlines stay up; this cycle only lets the bitlines settle.
                    state_r <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    rd_data1_r <= operand_select(rs1_r, bus.wr_en, bus.wr_addr,
                                                 bus.wr_data, bus.Bitline1);
                    rd_data2_r <= operand_select(rs2_r, bus.wr_en, bus.wr_addr,
                                                 bus.wr_data, bus.Bitline2);
                    wl1_r      <= {NUM_REGS{1'b0}};
                    wl2_r      <= {NUM_REGS{1'b0}};
                    rd_valid_r <= 1'b1;
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Operands are a snapshot; later writes are not tracked here.
                    if (bus.rd_ready) begin
                        rd_valid_r  <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    wl1_r       <= {NUM_REGS{1'b0}};
                    wl2_r       <= {NUM_REGS{1'b0}};
                    rd_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.ReadEnable1 = wl1_r;
    assign bus.ReadEnable2 = wl2_r;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.rd_data1    = rd_data1_r;
    assign bus.rd_data2    = rd_data2_r;

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_sequencer
// Two sequencers (ZERO_REG=0 and ZERO_REG=1) share one stimulus stream and one
// behavioural array. The array drives each bus from that DUT's wordlines and
// shows 16'hDEAD when no wordline is up. Expected operands come from a shadow
// copy of the register contents: an operand equals the most recent value
// written to its register up to and including the sample edge.
// -----------------------------------------------------------------------------
module tb_regfile_read_sequencer;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int WIDTH    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_ready;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem    [16];
    logic [15:0] shadow [16];
    logic [15:0] b_a1, b_a2, b_z1, b_z2;

    always #5 clk = ~clk;

    regfile_read_sequencer_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) ifa();
    regfile_read_sequencer_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) ifz();

    regfile_read_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .ZERO_REG(0))
        dut (.clk(clk), .rst(rst), .bus(ifa));
    regfile_read_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .ZERO_REG(1))
        dut_z (.clk(clk), .rst(rst), .bus(ifz));

    assign ifa.req_valid = req_valid;
    assign ifa.rs1       = rs1;
    assign ifa.rs2       = rs2;
    assign ifa.wr_en     = wr_en;
    assign ifa.wr_addr   = wr_addr;
    assign ifa.wr_data   = wr_data;
    assign ifa.rd_ready  = rd_ready;
    assign ifz.req_valid = req_valid;
    assign ifz.rs1       = rs1;
    assign ifz.rs2       = rs2;
    assign ifz.wr_en     = wr_en;
    assign ifz.wr_addr   = wr_addr;
    assign ifz.wr_data   = wr_data;
    assign ifz.rd_ready  = rd_ready;
    assign ifa.Bitline1  = b_a1;
    assign ifa.Bitline2  = b_a2;
    assign ifz.Bitline1  = b_z1;
    assign ifz.Bitline2  = b_z2;

    // Array cells update on the clock edge.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Bitline buses: wired-OR of enabled cells, garbage pattern when floating.
    always_comb begin
        b_a1 = 16'h0000;
        b_a2 = 16'h0000;
        b_z1 = 16'h0000;
        b_z2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (ifa.ReadEnable1[i]) b_a1 = b_a1 | mem[i];
            if (ifa.ReadEnable2[i]) b_a2 = b_a2 | mem[i];
            if (ifz.ReadEnable1[i]) b_z1 = b_z1 | mem[i];
            if (ifz.ReadEnable2[i]) b_z2 = b_z2 | mem[i];
        end
        if (ifa.ReadEnable1 == 16'h0000) b_a1 = 16'hDEAD;
        if (ifa.ReadEnable2 == 16'h0000) b_a2 = 16'hDEAD;
        if (ifz.ReadEnable1 == 16'h0000) b_z1 = 16'hDEAD;
        if (ifz.ReadEnable2 == 16'h0000) b_z2 = 16'hDEAD;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] exp_val(input bit zero, input logic [3:0] addr);
        if (zero && addr == 4'd0) return 16'h0000;
        return shadow[addr];
    endfunction

    function automatic logic [15:0] exp_wl(input bit zero, input logic [3:0] addr);
        logic [15:0] one_v;
        one_v = 16'h0001;
        if (zero && addr == 4'd0) return 16'h0000;
        return one_v << addr;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        if (wr_en && rst) shadow[wr_addr] = wr_data;
        else if (wr_en) shadow[wr_addr] = wr_data;
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        req_valid = 1'b1; rs1 = a; rs2 = b;
        step();
        req_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({ifa.req_ready, ifa.rd_valid, ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_data1, ifa.rd_data2}
            !== {1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b we1=%h we2=%h d1=%h d2=%h want rdy=1 vld=0 rest 0",
                     ifa.req_ready, ifa.rd_valid, ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_data1, ifa.rd_data2);
        end
        rst = 1'b1;
        preload(4'd3, 16'hA5A5);
        preload(4'd7, 16'h1234);
        issue(4'd3, 4'd7);
        checks++;
        if ({ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid, ifa.req_ready} !== {16'h0008, 16'h0080, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drive_wl: got we1=%h we2=%h vld=%b rdy=%b want 0008 0080 0 0",
                     ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid, ifa.req_ready);
        end
        step();
        checks++;
        if ({ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid} !== {16'h0008, 16'h0080, 1'b0}) begin
            errors++;
            $display("FAIL sample_wl: got we1=%h we2=%h vld=%b want 0008 0080 0",
                     ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid);
        end
        step();
        checks++;
        if ({ifa.rd_valid, ifa.rd_data1, ifa.rd_data2, ifa.ReadEnable1, ifa.ReadEnable2}
            !== {1'b1, 16'hA5A5, 16'h1234, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL first_read: got vld=%b d1=%h d2=%h we1=%h we2=%h want 1 a5a5 1234 0 0",
                     ifa.rd_valid, ifa.rd_data1, ifa.rd_data2, ifa.ReadEnable1, ifa.ReadEnable2);
        end
        checks++;
        if ({ifz.rd_valid, ifz.rd_data1, ifz.rd_data2} !== {1'b1, 16'hA5A5, 16'h1234}) begin
            errors++;
            $display("FAIL first_read_z: got vld=%b d1=%h d2=%h want 1 a5a5 1234",
                     ifz.rd_valid, ifz.rd_data1, ifz.rd_data2);
        end
        step();
        checks++;
        if ({ifa.req_ready, ifa.rd_valid} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_idle: got rdy=%b vld=%b want 1 0", ifa.req_ready, ifa.rd_valid);
        end
    endtask

    task automatic test_bypass();
        preload(4'd5, 16'h0001);
        rd_ready = 1'b0;
        issue(4'd5, 4'd3);
        step();                                   // now in SAMPLE
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        step();                                   // now in HOLD
        wr_en = 1'b0;
        checks++;
        if ({ifa.rd_valid, ifa.rd_data1, ifa.rd_data2} !== {1'b1, 16'hBEEF, exp_val(1'b0, 4'd3)}) begin
            errors++;
            $display("FAIL bypass_sample: got vld=%b d1=%h d2=%h want 1 beef %h",
                     ifa.rd_valid, ifa.rd_data1, ifa.rd_data2, exp_val(1'b0, 4'd3));
        end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1357;
        step();
        wr_en = 1'b0;
        checks++;
        if ({ifa.rd_valid, ifa.rd_data1} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL hold_write_ignored: got vld=%b d1=%h want 1 beef", ifa.rd_valid, ifa.rd_data1);
        end
        rd_ready = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] e1, e2;
        rd_ready = 1'b0;
        issue(4'd7, 4'd5);
        step(); step();                           // HOLD
        e1 = exp_val(1'b0, 4'd7);
        e2 = exp_val(1'b0, 4'd5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({ifa.rd_valid, ifa.req_ready, ifa.rd_data1, ifa.rd_data2, ifa.ReadEnable1, ifa.ReadEnable2}
                !== {1'b1, 1'b0, e1, e2, 16'h0000, 16'h0000}) begin
                errors++;
                $display("FAIL backpressure_c%0d: got vld=%b rdy=%b d1=%h d2=%h we1=%h we2=%h want 1 0 %h %h 0 0",
                         c, ifa.rd_valid, ifa.req_ready, ifa.rd_data1, ifa.rd_data2,
                         ifa.ReadEnable1, ifa.ReadEnable2, e1, e2);
            end
            req_valid = 1'b1; rs1 = 4'd2; rs2 = 4'd9;  // must be ignored outside IDLE
            step();
        end
        req_valid = 1'b0;
        rd_ready  = 1'b1;
        step();
        checks++;
        if ({ifa.rd_valid, ifa.req_ready, ifa.ReadEnable1} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL release_idle: got vld=%b rdy=%b we1=%h want 0 1 0",
                     ifa.rd_valid, ifa.req_ready, ifa.ReadEnable1);
        end
    endtask

    task automatic test_zero_reg();
        preload(4'd0, 16'hFFFF);
        issue(4'd0, 4'd0);
        checks++;
        if ({ifz.ReadEnable1, ifz.ReadEnable2, ifa.ReadEnable1, ifa.ReadEnable2}
            !== {16'h0000, 16'h0000, 16'h0001, 16'h0001}) begin
            errors++;
            $display("FAIL zero_drive_wl: got z=%h/%h a=%h/%h want 0/0 1/1",
                     ifz.ReadEnable1, ifz.ReadEnable2, ifa.ReadEnable1, ifa.ReadEnable2);
        end
        step();
        checks++;
        if ({ifz.ReadEnable1, ifz.ReadEnable2} !== 32'h0000_0000) begin
            errors++;
            $display("FAIL zero_sample_wl: got %h/%h want 0/0", ifz.ReadEnable1, ifz.ReadEnable2);
        end
        step();
        checks++;
        if ({ifz.rd_valid, ifz.rd_data1, ifz.rd_data2, ifa.rd_data1, ifa.rd_data2}
            !== {1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}) begin
            errors++;
            $display("FAIL zero_data: got zv=%b z=%h/%h a=%h/%h want 1 0/0 ffff/ffff",
                     ifz.rd_valid, ifz.rd_data1, ifz.rd_data2, ifa.rd_data1, ifa.rd_data2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(4'd3, 4'd7);
        step();                                   // SAMPLE
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid, ifa.rd_data1, ifa.rd_data2}
            !== {16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid: got we1=%h we2=%h vld=%b d1=%h d2=%h want all 0",
                     ifa.ReadEnable1, ifa.ReadEnable2, ifa.rd_valid, ifa.rd_data1, ifa.rd_data2);
        end
        step(); step();
        checks++;
        if ({ifa.rd_valid, ifa.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_hold: got vld=%b rdy=%b want 0 1", ifa.rd_valid, ifa.req_ready);
        end
        rst = 1'b1;
        step();
        issue(4'd7, 4'd3);
        step(); step();
        checks++;
        if ({ifa.rd_valid, ifa.rd_data1, ifa.rd_data2} !== {1'b1, exp_val(1'b0, 4'd7), exp_val(1'b0, 4'd3)}) begin
            errors++;
            $display("FAIL after_reset_read: got vld=%b d1=%h d2=%h want 1 %h %h",
                     ifa.rd_valid, ifa.rd_data1, ifa.rd_data2, exp_val(1'b0, 4'd7), exp_val(1'b0, 4'd3));
        end
        step();
    endtask

    task automatic test_sweep();
        int mode;
        logic [15:0] ea1, ea2, ez1, ez2;
        logic [3:0] a4, b4, wa;
        rd_ready = 1'b1;
        for (int r = 0; r < 16; r++) preload(4'(r), 16'($urandom));
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b);
                mode = $urandom_range(0, 3);
                case ($urandom_range(0, 2))
                    0:       wa = a4;
                    1:       wa = b4;
                    default: wa = 4'($urandom);
                endcase
                issue(a4, b4);                    // DRIVE
                checks++;
                if (!$onehot0(ifa.ReadEnable1) || !$onehot0(ifa.ReadEnable2) ||
                    !$onehot0(ifz.ReadEnable1) || !$onehot0(ifz.ReadEnable2) ||
                    {ifa.ReadEnable1, ifa.ReadEnable2, ifz.ReadEnable1, ifz.ReadEnable2} !==
                    {exp_wl(1'b0, a4), exp_wl(1'b0, b4), exp_wl(1'b1, a4), exp_wl(1'b1, b4)}) begin
                    errors++;
                    $display("FAIL sweep_wl rs=%0d,%0d: got a=%h/%h z=%h/%h want a=%h/%h z=%h/%h",
                             a, b, ifa.ReadEnable1, ifa.ReadEnable2, ifz.ReadEnable1, ifz.ReadEnable2,
                             exp_wl(1'b0, a4), exp_wl(1'b0, b4), exp_wl(1'b1, a4), exp_wl(1'b1, b4));
                end
                if (mode == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = 16'($urandom); end
                step();                           // SAMPLE
                wr_en = 1'b0;
                if (mode == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = 16'($urandom); end
                step();                           // HOLD
                wr_en = 1'b0;
                ea1 = exp_val(1'b0, a4); ea2 = exp_val(1'b0, b4);
                ez1 = exp_val(1'b1, a4); ez2 = exp_val(1'b1, b4);
                checks++;
                if ({ifa.rd_valid, ifa.rd_data1, ifa.rd_data2, ifz.rd_valid, ifz.rd_data1, ifz.rd_data2}
                    !== {1'b1, ea1, ea2, 1'b1, ez1, ez2}) begin
                    errors++;
                    $display("FAIL sweep_data rs=%0d,%0d mode=%0d: got a=%b %h %h z=%b %h %h want a=1 %h %h z=1 %h %h",
                             a, b, mode, ifa.rd_valid, ifa.rd_data1, ifa.rd_data2,
                             ifz.rd_valid, ifz.rd_data1, ifz.rd_data2, ea1, ea2, ez1, ez2);
                end
                if (mode == 3) begin wr_en = 1'b1; wr_addr = wa; wr_data = 16'($urandom); end
                step();                           // IDLE
                wr_en = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        rs1       = 4'd0;
        rs2       = 4'd0;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 16'h0000;
        rd_ready  = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = 16'h0000;
        #1;
        test_reset();
        test_bypass();
        test_backpressure();
        test_zero_reg();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
